// File: rtl/fast_op_dispatcher.sv
// FAST decoder op dispatcher: latches a template on message start, captures
// the presence map from the first ingress path that delivers it, then issues
// one op word per template field in lane groups over a valid/ready handshake.
module fast_op_dispatcher #(
  parameter int BEAT_W        = 64,
  parameter int SUP_PATHS     = 4,
  parameter int NUM_TEMPLATES = 4,
  parameter int TFIELD_W      = 10,
  parameter int MAX_FIELDS    = 10,
  parameter int NUM_LANES     = 4,
  parameter int OP_W          = 32,
  parameter int PMAP_W        = 14,
  localparam int TID_W = (NUM_TEMPLATES > 1) ? $clog2(NUM_TEMPLATES) : 1,
  localparam int LEN_W = $clog2(MAX_FIELDS + 1)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             new_message,
  output logic                             msg_ready,
  input  logic [TID_W-1:0]                 TID,
  input  logic [TFIELD_W*MAX_FIELDS-1:0]   template,
  input  logic [LEN_W-1:0]                 template_len,
  input  logic [(BEAT_W+2)*SUP_PATHS-1:0]  dins,
  input  logic [SUP_PATHS-1:0]             field_complete,
  output logic [NUM_LANES-1:0]             out_valid,
  output logic [OP_W*NUM_LANES-1:0]        out_op,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             msg_done,
  output logic                             pmap_overflow
);

  localparam int LW = $clog2(PMAP_W + 1);
  localparam logic [LW-1:0]    LEFT_ONE  = LW'(1);
  localparam logic [LW-1:0]    LEFT_INIT = LW'(PMAP_W);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_PMAP = 2'd1,
    S_DISPATCH  = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [TFIELD_W*MAX_FIELDS-1:0] tmpl_q, tmpl_d;
  logic [LEN_W-1:0]               len_q, len_d;
  logic [TID_W-1:0]               tid_q, tid_d;
  logic [PMAP_W-1:0]              pmap_q, pmap_d;
  logic [LW-1:0]                  left_q, left_d;
  logic [LEN_W-1:0]               base_q, base_d;
  logic [NUM_LANES-1:0]           out_valid_q, out_valid_d;
  logic [OP_W*NUM_LANES-1:0]      out_op_q, out_op_d;
  logic                           ovf_q, ovf_d;
  logic                           msg_done_q, msg_done_d;
  logic                           msg_ready_q, msg_ready_d;
  logic                           busy_q, busy_d;

  logic                           hit_s;
  logic [PMAP_W-1:0]              hit_pmap_s;
  logic [PMAP_W-1:0]              pmap_src_s;
  logic [NUM_LANES-1:0]           grp_valid_s;
  logic [OP_W*NUM_LANES-1:0]      grp_op_s;
  logic                           grp_ovf_s;
  logic [LW-1:0]                  grp_left_s;
  logic [LEN_W-1:0]               grp_base_s;
  logic                           advance_s;
  logic                           unused_s;

  // Pack one op word from a field's presence, index, descriptor and TID.
  function automatic logic [OP_W-1:0] make_op(input logic present,
                                              input logic [LEN_W-1:0] idx,
                                              input logic [TFIELD_W-1:0] desc,
                                              input logic [TID_W-1:0] tid);
    logic [OP_W-1:0] op;
    op        = {OP_W{1'b0}};
    op[31]    = present;
    op[30]    = present;
    op[29:24] = 6'(idx);
    op[23:22] = desc[7:6];
    op[21:19] = desc[5:3];
    op[18]    = desc[8];
    op[17:16] = 2'(tid);
    return op;
  endfunction

  // Descriptor reserved bits and non-pmap beat data are intentionally ignored.
  assign unused_s = ^{dins, tmpl_q};

  // Lowest-index path with pmap flag and beat complete supplies the pmap.
  always_comb begin
    hit_s      = 1'b0;
    hit_pmap_s = {PMAP_W{1'b0}};
    for (int k = 0; k < SUP_PATHS; k++) begin
      if (!hit_s && dins[k*(BEAT_W+2)+BEAT_W+1] && field_complete[k]) begin
        hit_s      = 1'b1;
        hit_pmap_s = dins[k*(BEAT_W+2) +: PMAP_W];
      end else begin
        hit_pmap_s = hit_pmap_s;
      end
    end
  end

  // The first group is built straight from the arriving pmap, later ones from the latched copy.
  assign pmap_src_s = (state_q == S_WAIT_PMAP) ? hit_pmap_s : pmap_q;
  assign advance_s  = out_ready | ~out_valid_q[0];

  // Build the next op group, consuming pmap bits MSB-first in lane order.
  always_comb begin
    logic [LEN_W-1:0]    base_v;
    logic [LW-1:0]       left_v;
    logic                present_v;
    logic [TFIELD_W-1:0] desc_v;
    base_v      = base_q;
    left_v      = left_q;
    grp_valid_s = {NUM_LANES{1'b0}};
    grp_op_s    = {(OP_W*NUM_LANES){1'b0}};
    grp_ovf_s   = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      present_v = 1'b0;
      desc_v    = {TFIELD_W{1'b0}};
      if (base_v < len_q) begin
        desc_v = tmpl_q[int'(base_v)*TFIELD_W +: TFIELD_W];
        if (desc_v[9]) begin
          if (left_v != {LW{1'b0}}) begin
            present_v = pmap_src_s[int'(left_v)-1];
            left_v    = left_v - LEFT_ONE;
          end else begin
            present_v = 1'b0;
            grp_ovf_s = 1'b1;
          end
        end else begin
          present_v = 1'b1;
        end
        grp_valid_s[i]               = 1'b1;
        grp_op_s[i*OP_W +: OP_W]     = make_op(present_v, base_v, desc_v, tid_q);
        base_v                       = base_v + LEN_ONE;
      end else begin
        grp_valid_s[i] = 1'b0;
      end
    end
    grp_base_s = base_v;
    grp_left_s = left_v;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (new_message) state_d = S_WAIT_PMAP;
        else             state_d = S_IDLE;
      end
      S_WAIT_PMAP: begin
        if (hit_s) state_d = (len_q == {LEN_W{1'b0}}) ? S_DONE : S_DISPATCH;
        else       state_d = S_WAIT_PMAP;
      end
      S_DISPATCH: begin
        if (advance_s && (grp_valid_s == {NUM_LANES{1'b0}})) state_d = S_DONE;
        else                                                 state_d = S_DISPATCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output and datapath next values.
  always_comb begin
    tmpl_d      = tmpl_q;
    len_d       = len_q;
    tid_d       = tid_q;
    pmap_d      = pmap_q;
    left_d      = left_q;
    base_d      = base_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (new_message) begin
          tmpl_d = template;
          len_d  = template_len;
          tid_d  = TID;
          pmap_d = {PMAP_W{1'b0}};
          left_d = LEFT_INIT;
          base_d = {LEN_W{1'b0}};
          ovf_d  = 1'b0;
        end else begin
          ovf_d = ovf_q;
        end
      end
      S_WAIT_PMAP: begin
        if (hit_s) begin
          pmap_d      = hit_pmap_s;
          out_valid_d = grp_valid_s;
          out_op_d    = grp_op_s;
          left_d      = grp_left_s;
          base_d      = grp_base_s;
          ovf_d       = ovf_q | grp_ovf_s;
        end else begin
          pmap_d = pmap_q;
        end
      end
      S_DISPATCH: begin
        if (advance_s) begin
          out_valid_d = grp_valid_s;
          out_op_d    = grp_op_s;
          left_d      = grp_left_s;
          base_d      = grp_base_s;
          ovf_d       = ovf_q | grp_ovf_s;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      S_DONE:  out_valid_d = {NUM_LANES{1'b0}};
      default: out_valid_d = {NUM_LANES{1'b0}};
    endcase
    msg_done_d  = (state_d == S_DONE);
    msg_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmpl_q      <= {(TFIELD_W*MAX_FIELDS){1'b0}};
      len_q       <= {LEN_W{1'b0}};
      tid_q       <= {TID_W{1'b0}};
      pmap_q      <= {PMAP_W{1'b0}};
      left_q      <= {LW{1'b0}};
      base_q      <= {LEN_W{1'b0}};
      out_valid_q <= {NUM_LANES{1'b0}};
      out_op_q    <= {(OP_W*NUM_LANES){1'b0}};
      ovf_q       <= 1'b0;
      msg_done_q  <= 1'b0;
      msg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      tmpl_q      <= tmpl_d;
      len_q       <= len_d;
      tid_q       <= tid_d;
      pmap_q      <= pmap_d;
      left_q      <= left_d;
      base_q      <= base_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      ovf_q       <= ovf_d;
      msg_done_q  <= msg_done_d;
      msg_ready_q <= msg_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign msg_ready     = msg_ready_q;
  assign out_valid     = out_valid_q;
  assign out_op        = out_op_q;
  assign busy          = busy_q;
  assign msg_done      = msg_done_q;
  assign pmap_overflow = ovf_q;

endmodule

// File: tb/tb_fast_op_dispatcher.sv
// Directed bench for fast_op_dispatcher: default instance plus a PMAP_W=4
// instance driven in lock-step for the pmap overflow case.
module tb_fast_op_dispatcher;

  logic         clk;
  logic         rstn;
  logic         new_message;
  logic [1:0]   tid;
  logic [99:0]  tmpl;
  logic [3:0]   tlen;
  logic [263:0] dins;
  logic [3:0]   fcomp;
  logic         out_ready;

  logic         msg_ready, busy, msg_done, ovf;
  logic [3:0]   out_valid;
  logic [127:0] out_op;
  logic         msg_ready4, busy4, msg_done4, ovf4;
  logic [3:0]   out_valid4;
  logic [127:0] out_op4;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [9:0] D_A = 10'b1_1_10_011_000;  // uses_pmap, optional, op=2, dtype=3
  localparam logic [9:0] D_B = 10'b0_0_01_101_000;  // no pmap, op=1, dtype=5

  fast_op_dispatcher dut (
    .clk(clk), .rstn(rstn), .new_message(new_message), .msg_ready(msg_ready),
    .TID(tid), .template(tmpl), .template_len(tlen), .dins(dins),
    .field_complete(fcomp), .out_valid(out_valid), .out_op(out_op),
    .out_ready(out_ready), .busy(busy), .msg_done(msg_done), .pmap_overflow(ovf)
  );

  fast_op_dispatcher #(.PMAP_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .new_message(new_message), .msg_ready(msg_ready4),
    .TID(tid), .template(tmpl), .template_len(tlen), .dins(dins),
    .field_complete(fcomp), .out_valid(out_valid4), .out_op(out_op4),
    .out_ready(out_ready), .busy(busy4), .msg_done(msg_done4), .pmap_overflow(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_op(input logic p, input int idx, input logic [9:0] d,
                                        input logic [1:0] t);
    logic [5:0] ix;
    ix = 6'(idx);
    return {p, p, ix, d[7:6], d[5:3], d[8], t, 16'h0000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_tmpl(input logic [9:0] d);
    for (int i = 0; i < 10; i++) tmpl[i*10 +: 10] = d;
  endtask

  task automatic start_msg(input logic [1:0] t, input logic [3:0] len);
    tid         = t;
    tlen        = len;
    new_message = 1'b1;
    tick();
    new_message = 1'b0;
  endtask

  task automatic set_path(input int k, input logic [13:0] pm);
    dins[k*66 + 65] = 1'b1;
    dins[k*66 +: 14] = pm;
  endtask

  task automatic clear_paths();
    dins  = '0;
    fcomp = 4'b0000;
  endtask

  initial begin
    rstn = 1'b0; new_message = 1'b0; tid = 2'd0; tmpl = '0; tlen = 4'd0;
    dins = '0; fcomp = 4'b0000; out_ready = 1'b1;
    #12;
    chk("rst_msg_ready", msg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_op", out_op, 0);
    chk("rst_done", msg_done, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk); rstn = 1'b1;
    tick();

    // TID=2, len=6, all pmap, pmap on path 1 = 101100...
    fill_tmpl(D_A);
    start_msg(2'd2, 4'd6);
    chk("t2_busy", busy, 1);
    chk("t2_ready_low", msg_ready, 0);
    set_path(1, 14'b101100_00000000); fcomp = 4'b0010;
    tick(); clear_paths();
    chk("t2_g1_valid", out_valid, 4'b1111);
    chk("t2_g1_op", out_op, {mk_op(1,3,D_A,2), mk_op(1,2,D_A,2), mk_op(0,1,D_A,2), mk_op(1,0,D_A,2)});
    tick();
    chk("t2_g2_valid", out_valid, 4'b0011);
    chk("t2_g2_op", out_op, {64'h0, mk_op(0,5,D_A,2), mk_op(0,4,D_A,2)});
    tick();
    chk("t2_done", msg_done, 1);
    chk("t2_done_valid", out_valid, 0);
    chk("t2_done_ready", msg_ready, 0);
    tick();
    chk("t2_done_pulse", msg_done, 0);
    chk("t2_idle_ready", msg_ready, 1);
    chk("t2_idle_busy", busy, 0);

    // len=5, fields 0,2 without pmap, pmap 011...
    tmpl = '0;
    tmpl[9:0] = D_B; tmpl[19:10] = D_A; tmpl[29:20] = D_B; tmpl[39:30] = D_A; tmpl[49:40] = D_A;
    start_msg(2'd1, 4'd5);
    set_path(0, 14'b011_00000000000); fcomp = 4'b0001;
    tick(); clear_paths();
    chk("t3_g1_op", out_op, {mk_op(1,3,D_A,1), mk_op(1,2,D_B,1), mk_op(0,1,D_A,1), mk_op(1,0,D_B,1)});
    tick();
    chk("t3_g2_valid", out_valid, 4'b0001);
    chk("t3_g2_op", out_op, {96'h0, mk_op(1,4,D_A,1)});
    chk("t3_ovf", ovf, 0);
    tick(); tick();

    // Back-pressure: group held while out_ready=0; new_message ignored while busy
    fill_tmpl(D_A);
    start_msg(2'd3, 4'd6);
    out_ready = 1'b0;
    set_path(2, 14'h3FFF); fcomp = 4'b0100;
    tick(); clear_paths();
    tlen = 4'd1; new_message = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("t4_hold_valid", out_valid, 4'b1111);
      chk("t4_hold_op", out_op, {mk_op(1,3,D_A,3), mk_op(1,2,D_A,3), mk_op(1,1,D_A,3), mk_op(1,0,D_A,3)});
      tick();
    end
    new_message = 1'b0;
    chk("t4_hold_last", out_valid, 4'b1111);
    out_ready = 1'b1;
    tick();
    chk("t4_g2_valid", out_valid, 4'b0011);
    chk("t4_g2_op", out_op, {64'h0, mk_op(1,5,D_A,3), mk_op(1,4,D_A,3)});
    tick();
    chk("t4_done", msg_done, 1);
    new_message = 1'b1;
    tick();
    new_message = 1'b0;
    chk("t4_done_ignores_new", busy, 0);
    chk("t4_idle_ready", msg_ready, 1);

    // Path priority: flag on 0 and 3 but only path 3 complete
    fill_tmpl(D_A);
    start_msg(2'd0, 4'd2);
    set_path(0, 14'b01_000000000000); fcomp = 4'b0000;
    tick();
    chk("t5_no_complete_wait", out_valid, 0);
    chk("t5_no_complete_busy", busy, 1);
    set_path(3, 14'b10_000000000000); fcomp = 4'b1001 & 4'b1000;
    tick(); clear_paths();
    chk("t5_path3_op", out_op, {64'h0, mk_op(0,1,D_A,0), mk_op(1,0,D_A,0)});
    tick(); tick(); tick();

    // Two complete paths: lowest index wins
    start_msg(2'd0, 4'd1);
    set_path(1, 14'b0_1111111111111); set_path(2, 14'b1_0000000000000); fcomp = 4'b0110;
    tick(); clear_paths();
    chk("t5b_lowest_wins", out_op, {96'h0, mk_op(0,0,D_A,0)});
    tick(); tick(); tick();

    // len=0: straight to DONE
    start_msg(2'd1, 4'd0);
    set_path(0, 14'h0); fcomp = 4'b0001;
    tick(); clear_paths();
    chk("t6_len0_done", msg_done, 1);
    chk("t6_len0_valid", out_valid, 0);
    tick();

    // Overflow on the PMAP_W=4 instance
    fill_tmpl(D_A);
    start_msg(2'd0, 4'd6);
    set_path(0, 14'b00000000001111); fcomp = 4'b0001;
    tick(); clear_paths();
    chk("t7_g1_op4", out_op4, {mk_op(1,3,D_A,0), mk_op(1,2,D_A,0), mk_op(1,1,D_A,0), mk_op(1,0,D_A,0)});
    chk("t7_g1_ovf", ovf4, 0);
    tick();
    chk("t7_g2_op4", out_op4, {64'h0, mk_op(0,5,D_A,0), mk_op(0,4,D_A,0)});
    chk("t7_g2_ovf", ovf4, 1);
    chk("t7_wide_no_ovf", ovf, 0);
    tick(); tick();
    chk("t7_sticky", ovf4, 1);
    start_msg(2'd0, 4'd0);
    chk("t7_cleared", ovf4, 0);
    set_path(0, 14'h0); fcomp = 4'b0001;
    tick(); clear_paths();
    tick();

    // Reset mid-DISPATCH with second group pending: abort, no done pulse
    start_msg(2'd1, 4'd6);
    out_ready = 1'b0;
    set_path(0, 14'h3FFF); fcomp = 4'b0001;
    tick(); clear_paths();
    chk("t8_pre_valid", out_valid, 4'b1111);
    #2 rstn = 1'b0;
    #1;
    chk("t8_rst_valid", out_valid, 0);
    chk("t8_rst_busy", busy, 0);
    chk("t8_rst_ready", msg_ready, 1);
    out_ready = 1'b1;
    @(negedge clk); rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t8_no_done", msg_done, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
